// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the multiply/divide unit.
//   muldiv_op_t     - func3 operation encodings
//   muldiv_state_t  - sequencer states of alu_muldiv
//   M_FUNC7_DEFAULT - func7 value that selects the multiply/divide group
package alu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } muldiv_state_t;

    localparam logic [6:0] M_FUNC7_DEFAULT = 7'b0000001;

endpackage

// File: rtl/div_core.sv
// div_core: restoring divider on unsigned magnitudes, one quotient bit per step.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   i_start       - load dividend/divisor and clear the partial remainder
//   i_step        - perform one iteration
//   i_dividend    - dividend magnitude (sampled on i_start)
//   i_divisor     - divisor magnitude (sampled on i_start)
//   o_quotient    - quotient including the iteration performed this cycle
//   o_remainder   - remainder including the iteration performed this cycle
// The outputs show the post-step value so the caller can capture the final
// result on the same edge that performs the last iteration.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // Trial subtraction: shift the next dividend bit into the remainder and restore on borrow.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_dvs};
        if (!w_diff[WIDTH]) begin
            o_remainder = w_diff[WIDTH-1:0];
            o_quotient  = {r_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_remainder = w_shift[WIDTH-1:0];
            o_quotient  = {r_quo[WIDTH-2:0], 1'b0};
        end
    end

    // Iteration registers: the quotient register doubles as the dividend shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= {WIDTH{1'b0}};
            r_rem <= {WIDTH{1'b0}};
            r_dvs <= {WIDTH{1'b0}};
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= {WIDTH{1'b0}};
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_quo <= o_quotient;
            r_rem <= o_remainder;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RISC-V style multiply/divide unit.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   valid_i         - request; accepted when ready_o && !flush_i
//   func3, func7    - operation select; func7 must equal M_FUNC7
//   a_i, b_i        - rs1 / rs2 operands
//   flush_i         - abort any in-flight operation (no done_o)
//   ready_o         - idle and able to accept
//   done_o          - one-cycle pulse, result_o/illegal_o valid
//   result_o        - result, held until the next completion
//   illegal_o       - accompanies done_o for an illegal request
// Configuration: define ALU_MULDIV_DIV_EN to build the divider; otherwise
// DIV/DIVU/REM/REMU complete as illegal requests.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int         WIDTH   = 32,
    parameter logic [6:0] M_FUNC7 = M_FUNC7_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             illegal_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement magnitude when the operand is treated as negative.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    muldiv_state_t      r_state, w_state_nxt;
    muldiv_op_t         r_op, w_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_result;
    logic               r_done, r_illegal;

    logic               w_accept, w_legal, w_last;
    logic               w_sa, w_sb, w_fast;
    logic [WIDTH-1:0]   w_fast_res, w_mag_a, w_mag_b, w_mul_res;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_nxt, w_prod_fin;

    assign w_op     = muldiv_op_t'(func3);
    assign w_accept = valid_i && ready_o && !flush_i;
`ifdef ALU_MULDIV_DIV_EN
    assign w_legal  = (func7 == M_FUNC7);
`else
    assign w_legal  = (func7 == M_FUNC7) && !func3[2];
`endif
    assign w_mag_a  = mag(a_i, w_sa);
    assign w_mag_b  = mag(b_i, w_sb);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Request decode: operand signedness and the single-cycle completion cases.
    always_comb begin
        w_sa       = 1'b0;
        w_sb       = 1'b0;
        w_fast     = !w_legal;
        w_fast_res = {WIDTH{1'b0}};
        case (w_op)
            OP_MUL, OP_MULH: begin
                w_sa = a_i[WIDTH-1];
                w_sb = b_i[WIDTH-1];
            end
            OP_MULHSU: w_sa = a_i[WIDTH-1];
`ifdef ALU_MULDIV_DIV_EN
            OP_DIV, OP_REM: begin
                w_sa = a_i[WIDTH-1];
                w_sb = b_i[WIDTH-1];
            end
`endif
            default: begin
                w_sa = 1'b0;
                w_sb = 1'b0;
            end
        endcase
`ifdef ALU_MULDIV_DIV_EN
        if (w_legal && func3[2]) begin
            if (b_i == {WIDTH{1'b0}}) begin
                w_fast     = 1'b1;
                w_fast_res = func3[1] ? a_i : {WIDTH{1'b1}};
            end else if (w_sa && w_sb && (a_i == MOST_NEG) && (b_i == {WIDTH{1'b1}})) begin
                // Signed overflow: quotient wraps to most-negative, remainder is zero.
                w_fast     = 1'b1;
                w_fast_res = func3[1] ? {WIDTH{1'b0}} : MOST_NEG;
            end else begin
                w_fast     = 1'b0;
            end
        end else begin
            w_fast_res = {WIDTH{1'b0}};
        end
`endif
    end

    // Shift-add step on magnitudes; sign applied to the full product at completion.
    always_comb begin
        w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
        w_prod_fin = r_neg ? (~w_prod_nxt + (2*WIDTH)'(1)) : w_prod_nxt;
        if (r_op == OP_MUL) begin
            w_mul_res = w_prod_fin[WIDTH-1:0];
        end else begin
            w_mul_res = w_prod_fin[2*WIDTH-1:WIDTH];
        end
    end

`ifdef ALU_MULDIV_DIV_EN
    logic             r_neg_rem;
    logic [WIDTH-1:0] w_quo, w_rem, w_div_res;

    div_core #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_accept && func3[2] && !w_fast),
        .i_step      ((r_state == S_DIV) && !flush_i),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Quotient sign is sign(a)^sign(b); remainder follows the dividend.
    always_comb begin
        if (r_op[1]) begin
            w_div_res = mag(w_rem, r_neg_rem);
        end else begin
            w_div_res = mag(w_quo, r_neg);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fast)        w_state_nxt = S_FIN;
                    else if (func3[2]) w_state_nxt = S_DIV;
                    else               w_state_nxt = S_MUL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: w_state_nxt = w_last ? S_FIN : r_state;
            S_FIN:        w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Datapath: operand latch, iteration, and registered result/done/illegal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_cnt     <= {CNT_W{1'b0}};
            r_neg     <= 1'b0;
            r_mcand   <= {WIDTH{1'b0}};
            r_prod    <= {(2*WIDTH){1'b0}};
            r_result  <= {WIDTH{1'b0}};
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            r_neg_rem <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            if (w_accept) begin
                r_op    <= w_op;
                r_cnt   <= {CNT_W{1'b0}};
                r_neg   <= w_sa ^ w_sb;
                r_mcand <= w_mag_a;
                r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
`ifdef ALU_MULDIV_DIV_EN
                r_neg_rem <= w_sa;
`endif
                if (w_fast) begin
                    r_result  <= w_fast_res;
                    r_illegal <= !w_legal;
                    r_done    <= 1'b1;
                end
            end else if (!flush_i && (r_state == S_MUL)) begin
                r_prod <= w_prod_nxt;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= w_mul_res;
                    r_done   <= 1'b1;
                end
`ifdef ALU_MULDIV_DIV_EN
            end else if (!flush_i && (r_state == S_DIV)) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_result <= w_div_res;
                    r_done   <= 1'b1;
                end
`endif
            end
        end
    end

    assign ready_o   = (r_state == S_IDLE);
    assign done_o    = r_done;
    assign result_o  = r_result;
    assign illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_muldiv.sv
`timescale 1ns/1ps
module tb_alu_muldiv;

    localparam int W = 32;
`ifdef ALU_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    logic [2:0]   func3;
    logic [6:0]   func7;
    logic [W-1:0] a_i, b_i;
    logic         flush_i;
    logic         ready_o, done_o, illegal_o;
    logic [W-1:0] result_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [31:0] last_res;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          at;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        logic        ill;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    alu_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .func3     (func3),
        .func7     (func7),
        .a_i       (a_i),
        .b_i       (b_i),
        .flush_i   (flush_i),
        .ready_o   (ready_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .illegal_o (illegal_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference for the request: illegal func7 (or divide when not built) -> 0, illegal, t+1.
    function automatic vec_t mk(input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] er, input int lat);
        vec_t v;
        v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
        if (f7 != 7'h01 || (f3[2] && !DIV_EN)) begin
            v.er = 32'h0; v.ill = 1'b1; v.lat = 1;
        end else begin
            v.er = er; v.ill = 1'b0; v.lat = lat;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard check of any completion seen at this sample point.
    task automatic check_done();
        exp_t e;
        if (!rst && done_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h expected no done (cycle %0d)", result_o, cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk1("illegal", illegal_o, e.ill);
                chk("done_cycle", 32'(cyc), 32'(e.at));
                last_res = e.res;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_done();
    endtask

    task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ill,
                         input int lat, input bit push, output int t);
        int n;
        n = 0;
        tick();
        while (!ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!ready_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_wait: got ready 0 expected 1 within 200 cycles");
        end
        func3 = f3; func7 = f7; a_i = a; b_i = b; valid_i = 1'b1;
        t = cyc;
        if (push) sb.push_back('{er, ill, t + lat});
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int t;
        int n;
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        func3 = 3'd0; func7 = 7'd0; a_i = 32'd0; b_i = 32'd0; last_res = 32'd0;
        repeat (2) @(negedge clk);
        chk1("rst_ready", ready_o, 1'b1);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_illegal", illegal_o, 1'b0);
        chk("rst_result", result_o, 32'h0);
        rst = 1'b0;

        vecs.push_back(mk(3'b000, 7'h01, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33));
        vecs.push_back(mk(3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33));
        vecs.push_back(mk(3'b001, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33));
        vecs.push_back(mk(3'b010, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(3'b001, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 33));
        vecs.push_back(mk(3'b011, 7'h01, 32'h80000000, 32'h00000002, 32'h00000001, 33));
        vecs.push_back(mk(3'b000, 7'h01, 32'h3,        32'h4,        32'hC,        33));
        vecs.push_back(mk(3'b100, 7'h01, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33));
        vecs.push_back(mk(3'b110, 7'h01, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33));
        vecs.push_back(mk(3'b101, 7'h01, 32'h5,        32'h0,        32'hFFFFFFFF, 1));
        vecs.push_back(mk(3'b111, 7'h01, 32'h5,        32'h0,        32'h5,        1));
        vecs.push_back(mk(3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
        vecs.push_back(mk(3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1));
        vecs.push_back(mk(3'b110, 7'h01, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1));
        vecs.push_back(mk(3'b101, 7'h01, 32'd100,      32'd7,        32'd14,       33));
        vecs.push_back(mk(3'b111, 7'h01, 32'd100,      32'd7,        32'd2,        33));
        vecs.push_back(mk(3'b100, 7'h01, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33));
        vecs.push_back(mk(3'b110, 7'h01, 32'h7,        32'hFFFFFFFE, 32'h1,        33));
        vecs.push_back(mk(3'b101, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h0,        33));
        vecs.push_back(mk(3'b000, 7'h20, 32'h3,        32'h4,        32'hC,        33));

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].er, vecs[i].ill, vecs[i].lat, 1'b1, t);
            wait_idle();
        end

        // Back-to-back: ready again in the cycle after done.
        issue(3'b000, 7'h01, 32'd9, 32'd9, 32'd81, 1'b0, 33, 1'b1, t);
        n = 0;
        while (done_o !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk1("b2b_done_seen", done_o, 1'b1);
        tick();
        chk1("b2b_ready", ready_o, 1'b1);
        wait_idle();

        // Flush a MUL at t+10: idle at t+11, no done, result held.
        issue(3'b000, 7'h01, 32'd5, 32'd6, 32'd30, 1'b0, 33, 1'b0, t);
        chk1("busy_ready", ready_o, 1'b0);
        repeat (10) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_cycle", 32'(cyc), 32'(t + 11));
        chk1("flush_ready", ready_o, 1'b1);
        chk("flush_result", result_o, last_res);
        repeat (40) tick();

        // Flush together with valid in idle: request is not taken.
        tick();
        func3 = 3'b000; func7 = 7'h01; a_i = 32'd1; b_i = 32'd1;
        valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0; flush_i = 1'b0;
        chk1("flush_valid_ready", ready_o, 1'b1);
        repeat (40) tick();

        // Reset at t+5 of a long operation, then a fresh multiply.
        issue(DIV_EN ? 3'b100 : 3'b000, 7'h01, 32'd100, 32'd7, 32'd0, 1'b0, 33, 1'b0, t);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk1("midrst_ready", ready_o, 1'b1);
        chk1("midrst_done", done_o, 1'b0);
        chk1("midrst_illegal", illegal_o, 1'b0);
        chk("midrst_result", result_o, 32'h0);
        tick();
        rst = 1'b0;
        last_res = 32'h0;
        repeat (40) tick();
        issue(3'b000, 7'h01, 32'd3, 32'd4, 32'd12, 1'b0, 33, 1'b1, t);
        wait_idle();

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
